// File: rtl/lsu_mem_stage_if.sv
// Request/response bus between the EX/MEM pipeline register and the load/store unit.
// The pipeline side uses the master modport and the LSU uses the slave modport.
interface lsu_mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit: sequences word-wide DMEM accesses (read-modify-write for SB/SH) and
// aligns/extends load data. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_mem_stage #(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  lsu_mem_stage_if.slave     bus,
  output logic [31:0]        DMEM_address,
  output logic [31:0]        DMEM_data_in,
  output logic               DMEM_mem_write,
  output logic               DMEM_mem_read,
  input  logic [31:0]        DMEM_data_out
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_SETUP = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic [15:0] nw,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = old_word;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    r[7:0]   = nw[7:0];
          2'd1:    r[15:8]  = nw[7:0];
          2'd2:    r[23:16] = nw[7:0];
          2'd3:    r[31:24] = nw[7:0];
          default: r = old_word;
        endcase
      end
      2'b01: begin
        if (lane[1]) begin
          r[31:16] = nw;
        end else begin
          r[15:0] = nw;
        end
      end
      default: r = old_word;
    endcase
    return r;
  endfunction

  // Low address bits beyond the access size are dropped, so a half uses lane 0 or 2.
  function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] r;
    case (size)
      2'b00:   r = lo;
      2'b01:   r = {lo[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = lo[0];
      default: r = (lo != 2'b00);
    endcase
    return r;
  endfunction

  state_t      state_r, state_nx_s;
  logic        ready_r, ready_nx_s;
  logic        resp_valid_r, resp_valid_nx_s;
  logic [31:0] rdata_r, rdata_nx_s;
  logic        err_r, err_nx_s;
  logic [31:0] dmem_addr_r, dmem_addr_nx_s;
  logic [31:0] dmem_wdata_r, dmem_wdata_nx_s;
  logic        mem_write_r, mem_write_nx_s;
  logic        mem_read_r, mem_read_nx_s;
  logic        wr_r, wr_nx_s;
  logic [1:0]  size_r, size_nx_s;
  logic        uns_r, uns_nx_s;
  logic [1:0]  lane_r, lane_nx_s;
  logic [15:0] wdata_r, wdata_nx_s;
  logic        trap_s;
  logic [31:0] word_idx_s;
  logic        unused_s;

  assign word_idx_s = {{(32-ADDR_W){1'b0}}, bus.req_addr[ADDR_W+1:2]};
  assign unused_s   = ^{1'b0, bus.req_addr[31:ADDR_W+2]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_s = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_nx_s      = state_r;
    ready_nx_s      = 1'b0;
    resp_valid_nx_s = 1'b0;
    rdata_nx_s      = rdata_r;
    err_nx_s        = err_r;
    dmem_addr_nx_s  = dmem_addr_r;
    dmem_wdata_nx_s = dmem_wdata_r;
    mem_write_nx_s  = 1'b0;
    mem_read_nx_s   = 1'b0;
    wr_nx_s         = wr_r;
    size_nx_s       = size_r;
    uns_nx_s        = uns_r;
    lane_nx_s       = lane_r;
    wdata_nx_s      = wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          wr_nx_s    = bus.req_write;
          size_nx_s  = bus.req_size;
          uns_nx_s   = bus.req_unsigned;
          lane_nx_s  = align_lane(bus.req_size, bus.req_addr[1:0]);
          wdata_nx_s = bus.req_wdata[15:0];
          if (trap_s) begin
            state_nx_s      = ST_RESP;
            resp_valid_nx_s = 1'b1;
            rdata_nx_s      = 32'd0;
            err_nx_s        = 1'b1;
          end else if (bus.req_write && bus.req_size[1]) begin
            // Full-word store skips the read; data and address settle one cycle before the strobe.
            state_nx_s      = ST_SETUP;
            dmem_addr_nx_s  = word_idx_s;
            dmem_wdata_nx_s = bus.req_wdata;
          end else begin
            state_nx_s     = ST_READ;
            dmem_addr_nx_s = word_idx_s;
            mem_read_nx_s  = 1'b1;
          end
        end else begin
          ready_nx_s = 1'b1;
        end
      end
      ST_READ: begin
        if (wr_r) begin
          state_nx_s      = ST_SETUP;
          dmem_wdata_nx_s = merge_store(DMEM_data_out, wdata_r, size_r, lane_r);
        end else begin
          state_nx_s      = ST_RESP;
          resp_valid_nx_s = 1'b1;
          rdata_nx_s      = load_extract(DMEM_data_out, size_r, lane_r, uns_r);
          err_nx_s        = 1'b0;
        end
      end
      ST_SETUP: begin
        state_nx_s     = ST_WRITE;
        mem_write_nx_s = 1'b1;
      end
      ST_WRITE: begin
        state_nx_s      = ST_RESP;
        resp_valid_nx_s = 1'b1;
        rdata_nx_s      = 32'd0;
        err_nx_s        = 1'b0;
      end
      ST_RESP: begin
        state_nx_s = ST_IDLE;
        ready_nx_s = 1'b1;
      end
      default: begin
        state_nx_s = ST_IDLE;
        ready_nx_s = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Output registers and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      rdata_r      <= 32'd0;
      err_r        <= 1'b0;
      dmem_addr_r  <= 32'd0;
      dmem_wdata_r <= 32'd0;
      mem_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
      wr_r         <= 1'b0;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      lane_r       <= 2'b00;
      wdata_r      <= 16'd0;
    end else begin
      ready_r      <= ready_nx_s;
      resp_valid_r <= resp_valid_nx_s;
      rdata_r      <= rdata_nx_s;
      err_r        <= err_nx_s;
      dmem_addr_r  <= dmem_addr_nx_s;
      dmem_wdata_r <= dmem_wdata_nx_s;
      mem_write_r  <= mem_write_nx_s;
      mem_read_r   <= mem_read_nx_s;
      wr_r         <= wr_nx_s;
      size_r       <= size_nx_s;
      uns_r        <= uns_nx_s;
      lane_r       <= lane_nx_s;
      wdata_r      <= wdata_nx_s;
    end
  end

  assign bus.req_ready   = ready_r;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_rdata  = rdata_r;
  assign bus.resp_err    = err_r;
  assign DMEM_address    = dmem_addr_r;
  assign DMEM_data_in    = dmem_wdata_r;
  assign DMEM_mem_write  = mem_write_r;
  assign DMEM_mem_read   = mem_read_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: word-wide DMEM model, scoreboard of expected
// responses (data, error flag, latency), and strobe/reset checks.
module tb_lsu_mem_stage;
  logic        clk;
  logic        rst_n;
  logic [31:0] DMEM_address;
  logic [31:0] DMEM_data_in;
  logic        DMEM_mem_write;
  logic        DMEM_mem_read;
  logic [31:0] DMEM_data_out;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.ADDR_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .DMEM_address   (DMEM_address),
    .DMEM_data_in   (DMEM_data_in),
    .DMEM_mem_write (DMEM_mem_write),
    .DMEM_mem_read  (DMEM_mem_read),
    .DMEM_data_out  (DMEM_data_out)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          start;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mem [0:255];
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic        strobe_bad = 1'b0;
  logic        prev_w = 1'b0;
  logic [31:0] prev_a = 32'd0;
  logic [31:0] prev_d = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign DMEM_data_out = mem[DMEM_address[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && DMEM_mem_write) begin
      mem[DMEM_address[7:0]] <= DMEM_data_in;
      wr_cnt <= wr_cnt + 1;
    end
    if (rst_n && DMEM_mem_read) begin
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write strobe must not rise in a cycle where address or data moved.
  always @(negedge clk) begin
    if (DMEM_mem_write && !prev_w && (DMEM_address != prev_a || DMEM_data_in != prev_d)) begin
      strobe_bad <= 1'b1;
    end
    prev_w <= DMEM_mem_write;
    prev_a <= DMEM_address;
    prev_d <= DMEM_data_in;
  end

  // Response monitor: pop the scoreboard on each resp_valid.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_resp", {31'd0, bus.resp_valid}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("resp_rdata", bus.resp_rdata, mon_e.rdata);
        check_eq("resp_err", {31'd0, bus.resp_err}, {31'd0, mon_e.err});
        check_eq("resp_latency", cyc - mon_e.start, mon_e.lat);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input bit keep, output int waits);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    waits = n;
    check_eq("accept", {31'd0, bus.req_ready}, 32'd1);
    if (bus.req_ready) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = exp_lat;
      e.start = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", sb_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int w;
    int wc;
    int rc;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check_eq("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check_eq("rst_addr", DMEM_address, 32'd0);
    check_eq("rst_data_in", DMEM_data_in, 32'd0);
    check_eq("rst_strobes", {30'd0, DMEM_mem_write, DMEM_mem_read}, 32'd0);
    rst_n = 1'b1;

    // Reset during WRITE: strobes drop at once, no response, DMEM untouched
    mem[4] = 32'hCAFEF00D;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h11111111;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    while (!DMEM_mem_write && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_wr_seen", {31'd0, DMEM_mem_write}, 32'd1);
    wc = wr_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("abort_write", {31'd0, DMEM_mem_write}, 32'd0);
    check_eq("abort_read", {31'd0, DMEM_mem_read}, 32'd0);
    check_eq("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    check_eq("abort_resp", {31'd0, bus.resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_mem", mem[4], 32'hCAFEF00D);

    // Reset during SETUP of a byte store leaves DMEM unchanged
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 32'h11; bus.req_wdata = 32'h00000055;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("sb_read_strobe", {31'd0, DMEM_mem_read}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_sb_mem", mem[4], 32'hCAFEF00D);
    check_eq("abort_wr_cnt", wr_cnt, wc);
    repeat (4) @(negedge clk);

    // Loads with alignment and extension
    mem[1] = 32'h8899AABB;
    do_req(1'b0, 2'b00, 1'b0, 32'h6, 32'd0, 32'hFFFFFF99, 1'b0, 2, 1'b0, w); drain();
    do_req(1'b0, 2'b00, 1'b1, 32'h6, 32'd0, 32'h00000099, 1'b0, 2, 1'b0, w); drain();
    do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'd0, 32'hFFFF8899, 1'b0, 2, 1'b0, w); drain();
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'd0, 32'h8899AABB, 1'b0, 2, 1'b0, w); drain();
    do_req(1'b0, 2'b01, 1'b1, 32'h4, 32'd0, 32'h0000AABB, 1'b0, 2, 1'b0, w); drain();
    do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'd0, 32'hFFFFFFAA, 1'b0, 2, 1'b0, w); drain();
    do_req(1'b0, 2'b11, 1'b0, 32'h404, 32'd0, 32'h8899AABB, 1'b0, 2, 1'b0, w); drain();

    // Full-word store
    wc = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, 32'd0, 1'b0, 3, 1'b0, w); drain();
    check_eq("sw_mem", mem[2], 32'h12345678);
    check_eq("sw_wr_pulses", wr_cnt - wc, 32'd1);

    // Sub-word stores: only target lanes change
    wc = wr_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'hABCDEFEE, 32'd0, 1'b0, 4, 1'b0, w); drain();
    check_eq("sb_mem", mem[2], 32'h1234EE78);
    do_req(1'b1, 2'b01, 1'b0, 32'hA, 32'h5555BEEF, 32'd0, 1'b0, 4, 1'b0, w); drain();
    check_eq("sh_mem", mem[2], 32'hBEEFEE78);
    check_eq("sub_wr_pulses", wr_cnt - wc, 32'd2);

    // Back-to-back SW then LW to the same word with req_valid held
    do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'hA5A55A5A, 32'd0, 1'b0, 3, 1'b1, w);
    do_req(1'b0, 2'b10, 1'b0, 32'hC, 32'd0, 32'hA5A55A5A, 1'b0, 2, 1'b0, w);
    check_eq("b2b_ready_low", w, 32'd3);
    drain();

    // Misaligned accesses
    wc = wr_cnt;
    rc = rd_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 2'b10, 1'b0, 32'h5, 32'd0, 32'd0, 1'b1, 1, 1'b0, w); drain();
    do_req(1'b0, 2'b01, 1'b0, 32'h7, 32'd0, 32'd0, 1'b1, 1, 1'b0, w); drain();
    check_eq("trap_rd_cnt", rd_cnt - rc, 32'd0);
`else
    do_req(1'b0, 2'b10, 1'b0, 32'h5, 32'd0, 32'h8899AABB, 1'b0, 2, 1'b0, w); drain();
    do_req(1'b0, 2'b01, 1'b0, 32'h7, 32'd0, 32'hFFFF8899, 1'b0, 2, 1'b0, w); drain();
    check_eq("misalign_rd_cnt", rd_cnt - rc, 32'd2);
`endif
    check_eq("misalign_wr_cnt", wr_cnt - wc, 32'd0);

    check_eq("strobe_stable", {31'd0, strobe_bad}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
